// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: RV64 opcodes,
// the ECALL instruction word and the controller state type.
package pipe_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;

    localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_SVC     = 2'd3
    } state_e;

    function automatic logic uses_rs2(input logic [6:0] opc);
        return opc inside {OPC_OP, OPC_OP32, OPC_STORE, OPC_BRANCH};
    endfunction

    function automatic logic is_ctrl_xfer(input logic [6:0] opc);
        return opc inside {OPC_BRANCH, OPC_JAL, OPC_JALR};
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Status and latch-control bundle between the pipeline datapath (master)
// and the stall/flush sequencer (slave).
interface pipeline_ctrl_if;
    logic        de_v;
    logic [31:0] de_ir;
    logic        exe_v;
    logic [6:0]  exe_opc;
    logic [4:0]  exe_drid;
    logic        mem_stall;
    logic        br_resolved;
    logic        br_taken;
    logic        ecall_ack;

    logic        ld_pc;
    logic        pc_sel;
    logic        ld_de;
    logic        de_v_in;
    logic        ld_agex;
    logic        exe_v_in;
    logic        ld_mem;
    logic        ld_wb;
    logic        wb_v_in;
    logic        v_de_br_stall;
    logic        ecall_req;

    modport master (
        output de_v, de_ir, exe_v, exe_opc, exe_drid, mem_stall,
               br_resolved, br_taken, ecall_ack,
        input  ld_pc, pc_sel, ld_de, de_v_in, ld_agex, exe_v_in,
               ld_mem, ld_wb, wb_v_in, v_de_br_stall, ecall_req
    );

    modport slave (
        input  de_v, de_ir, exe_v, exe_opc, exe_drid, mem_stall,
               br_resolved, br_taken, ecall_ack,
        output ld_pc, pc_sel, ld_de, de_v_in, ld_agex, exe_v_in,
               ld_mem, ld_wb, wb_v_in, v_de_br_stall, ecall_req
    );
endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use compare between a load in AGEX and the
// source registers of the instruction waiting in DE.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       de_v,
    input  logic [6:0] de_opc,
    input  logic [4:0] de_rs1,
    input  logic [4:0] de_rs2,
    input  logic       exe_v,
    input  logic [6:0] exe_opc,
    input  logic [4:0] exe_drid,
    output logic       load_use
);

    logic exe_is_load;
    logic rs1_hit;
    logic rs2_hit;

    // A load targeting x0 never produces a value anyone waits for.
    assign exe_is_load = exe_v && (exe_opc == OPC_LOAD) && (exe_drid != 5'd0);
    assign rs1_hit     = (exe_drid == de_rs1);
    assign rs2_hit     = (exe_drid == de_rs2) && uses_rs2(de_opc);
    assign load_use    = de_v && exe_is_load && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV64 pipeline: load-use interlock,
// branch resolution wait, memory-stall freeze and ECALL drain.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int DRAIN_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_ctrl_if.slave   bus,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DRN_W = $clog2(DRAIN_DEPTH + 1);

    state_e           state, state_nxt;
    logic [DRN_W-1:0] drain_cnt, drain_nxt;
    logic             load_use;
    logic             de_ctrl;
    logic             de_ecall;

    hazard_detect u_hazard_detect (
        .de_v     (bus.de_v),
        .de_opc   (bus.de_ir[6:0]),
        .de_rs1   (bus.de_ir[19:15]),
        .de_rs2   (bus.de_ir[24:20]),
        .exe_v    (bus.exe_v),
        .exe_opc  (bus.exe_opc),
        .exe_drid (bus.exe_drid),
        .load_use (load_use)
    );

    assign de_ctrl  = bus.de_v && is_ctrl_xfer(bus.de_ir[6:0]);
    assign de_ecall = bus.de_v && (bus.de_ir == ECALL_INSN);

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // A stall or interlock freezes the sequence; a branch held back by a
    // load-use bubble enters BR_WAIT only once it actually moves to AGEX.
    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        if (!bus.mem_stall && !load_use) begin
            unique case (state)
                ST_RUN: begin
                    if (de_ctrl) begin
                        state_nxt = ST_BR_WAIT;
                    end else if (de_ecall) begin
                        state_nxt = ST_DRAIN;
                        drain_nxt = DRN_W'(DRAIN_DEPTH);
                    end
                end
                ST_BR_WAIT: if (bus.br_resolved) state_nxt = ST_RUN;
                ST_DRAIN: begin
                    drain_nxt = drain_cnt - DRN_W'(1);
                    if (drain_cnt == DRN_W'(1)) state_nxt = ST_SVC;
                end
                ST_SVC: if (bus.ecall_ack) state_nxt = ST_RUN;
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        bus.ld_pc     = 1'b1;
        bus.pc_sel    = 1'b0;
        bus.ld_de     = 1'b1;
        bus.de_v_in   = 1'b1;
        bus.ld_agex   = 1'b1;
        bus.exe_v_in  = bus.de_v;
        bus.ld_mem    = 1'b1;
        bus.ld_wb     = 1'b1;
        bus.wb_v_in   = 1'b1;
        bus.ecall_req = 1'b0;
        if (!rst_n) begin
            bus.ld_pc    = 1'b0;
            bus.ld_de    = 1'b0;
            bus.de_v_in  = 1'b0;
            bus.ld_agex  = 1'b0;
            bus.exe_v_in = 1'b0;
            bus.ld_mem   = 1'b0;
            bus.ld_wb    = 1'b0;
            bus.wb_v_in  = 1'b0;
        end else if (bus.mem_stall) begin
            // Everything up to MEM holds; WB drains with a bubble.
            bus.ld_pc    = 1'b0;
            bus.ld_de    = 1'b0;
            bus.de_v_in  = 1'b0;
            bus.ld_agex  = 1'b0;
            bus.exe_v_in = 1'b0;
            bus.ld_mem   = 1'b0;
            bus.wb_v_in  = 1'b0;
        end else if (load_use) begin
            bus.ld_pc    = 1'b0;
            bus.ld_de    = 1'b0;
            bus.exe_v_in = 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (de_ctrl || de_ecall) begin
                        bus.ld_pc   = 1'b0;
                        bus.de_v_in = 1'b0;
                    end
                end
                ST_BR_WAIT: begin
                    bus.ld_pc   = bus.br_resolved;
                    bus.pc_sel  = bus.br_resolved && bus.br_taken;
                    bus.de_v_in = 1'b0;
                end
                ST_DRAIN: begin
                    bus.ld_pc    = 1'b0;
                    bus.de_v_in  = 1'b0;
                    bus.exe_v_in = 1'b0;
                end
                ST_SVC: begin
                    bus.ld_pc     = bus.ecall_ack;
                    bus.de_v_in   = 1'b0;
                    bus.exe_v_in  = 1'b0;
                    bus.ecall_req = 1'b1;
                end
                default: bus.ld_pc = 1'b0;
            endcase
        end
    end

    assign bus.v_de_br_stall = (state == ST_BR_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!bus.ld_pc && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
